// File: rtl/pe_pkg.sv
// Shared types for the PE sequencer: FSM state encoding and the run-time configuration record.
package pe_pkg;

   localparam int CFG_FIELD_W = 16;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      PROCESS    = 3'd1,
      ACCUMULATE = 3'd2,
      STRIDE     = 3'd3,
      LOAD       = 3'd4,
      FINISH     = 3'd5
   } state_t;

   // Fields are wide enough to hold any configured *_WIDTH input zero-extended.
   typedef struct packed {
      logic [CFG_FIELD_W-1:0] S;
      logic [CFG_FIELD_W-1:0] F;
      logic [CFG_FIELD_W-1:0] U;
      logic [CFG_FIELD_W-1:0] n;
      logic [CFG_FIELD_W-1:0] p;
      logic [CFG_FIELD_W-1:0] q;
   } cfg_t;

endpackage

// File: rtl/pe_cfg_check.sv
// Combinational legality check of a run configuration against the scratchpad address ranges.
module pe_cfg_check import pe_pkg::*; #(
   parameter int IFMAP_ADDR_WIDTH  = 4,
   parameter int FILTER_ADDR_WIDTH = 8,
   parameter int PSUM_ADDR_WIDTH   = 5
) (
   input  cfg_t cfg,
   output logic cfg_ok
);

   logic [47:0] sq;
   logic [47:0] sqp;
   logic [47:0] ifmap_cap;
   logic [47:0] filter_cap;
   logic [47:0] psum_cap;
   logic        any_zero;

   always_comb begin
      sq         = 48'(cfg.S) * 48'(cfg.q);
      sqp        = sq * 48'(cfg.p);
      ifmap_cap  = 48'd1 << IFMAP_ADDR_WIDTH;
      filter_cap = 48'd1 << FILTER_ADDR_WIDTH;
      psum_cap   = 48'd1 << PSUM_ADDR_WIDTH;
      any_zero   = (cfg.S == '0) || (cfg.F == '0) || (cfg.U == '0) ||
                   (cfg.n == '0) || (cfg.p == '0) || (cfg.q == '0);
      cfg_ok     = !any_zero && (sq <= ifmap_cap) && (48'(cfg.p) <= psum_cap) &&
                   (sqp <= filter_cap);
   end

endmodule

// File: rtl/pe_sequencer.sv
// Row-stationary PE controller: MAC pass, ipsum accumulation, stride shift and ifmap reload per row.
module pe_sequencer import pe_pkg::*; #(
   parameter int F_WIDTH           = 6,
   parameter int S_WIDTH           = 4,
   parameter int U_WIDTH           = 3,
   parameter int N_WIDTH           = 3,
   parameter int P_WIDTH           = 5,
   parameter int Q_WIDTH           = 3,
   parameter int IFMAP_ADDR_WIDTH  = 4,
   parameter int FILTER_ADDR_WIDTH = 8,
   parameter int PSUM_ADDR_WIDTH   = 5
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         abort,
   input  logic                         await,
   input  logic                         skip_en,
   input  logic                         ifmap_zero,
   input  logic [S_WIDTH-1:0]           S,
   input  logic [F_WIDTH-1:0]           F,
   input  logic [U_WIDTH-1:0]           U,
   input  logic [N_WIDTH-1:0]           n,
   input  logic [P_WIDTH-1:0]           p,
   input  logic [Q_WIDTH-1:0]           q,
   output logic                         busy,
   output logic                         done,
   output logic                         cfg_error,
   output logic                         reset_accumulation,
   output logic                         accumulate_ipsum,
   output logic                         ipsum_pop,
   output logic                         opsum_push,
   output logic                         reset_ifmap_spad,
   output logic                         reset_filter_spad,
   output logic [IFMAP_ADDR_WIDTH-1:0]  ifmap_addr,
   output logic [FILTER_ADDR_WIDTH-1:0] filter_addr,
   output logic [PSUM_ADDR_WIDTH-1:0]   psum_addr,
   output logic                         shift,
   output logic                         rd_data,
   output logic                         wr_psum,
   input  logic                         ipsum_fifo_empty,
   input  logic                         opsum_fifo_full
);

   localparam int UQ_WIDTH    = U_WIDTH + Q_WIDTH;
   localparam int P_CNT_WIDTH = PSUM_ADDR_WIDTH + 1;

   state_t                      state, state_nx;
   logic [IFMAP_ADDR_WIDTH-1:0] i, i_nx, i_last, i_last_nx;
   logic [PSUM_ADDR_WIDTH-1:0]  j, j_nx, j_last, j_last_nx;
   logic [F_WIDTH-1:0]          f_cnt, f_cnt_nx, f_last, f_last_nx;
   logic [N_WIDTH-1:0]          n_cnt, n_cnt_nx, n_last, n_last_nx;
   logic [UQ_WIDTH-1:0]         u_cnt, u_cnt_nx, u_last, u_last_nx;
   logic [P_CNT_WIDTH-1:0]      p_cnt;
   logic [31:0]                 sq_in;
   cfg_t                        cfg_in;
   logic                        cfg_ok;

   always_comb begin
      cfg_in.S = CFG_FIELD_W'(S);
      cfg_in.F = CFG_FIELD_W'(F);
      cfg_in.U = CFG_FIELD_W'(U);
      cfg_in.n = CFG_FIELD_W'(n);
      cfg_in.p = CFG_FIELD_W'(p);
      cfg_in.q = CFG_FIELD_W'(q);
   end

   pe_cfg_check #(
      .IFMAP_ADDR_WIDTH  (IFMAP_ADDR_WIDTH),
      .FILTER_ADDR_WIDTH (FILTER_ADDR_WIDTH),
      .PSUM_ADDR_WIDTH   (PSUM_ADDR_WIDTH)
   ) u_cfg_check (
      .cfg    (cfg_in),
      .cfg_ok (cfg_ok)
   );

   assign sq_in       = 32'(cfg_in.S) * 32'(cfg_in.q);
   assign p_cnt       = {1'b0, j_last} + P_CNT_WIDTH'(1);
   assign ifmap_addr  = i;
   assign psum_addr   = j;
   assign filter_addr = FILTER_ADDR_WIDTH'(i) * FILTER_ADDR_WIDTH'(p_cnt) + FILTER_ADDR_WIDTH'(j);

   // State updates on the falling edge so the datapath sees stable strobes on the rising edge.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         i      <= '0;
         j      <= '0;
         f_cnt  <= '0;
         n_cnt  <= '0;
         u_cnt  <= '0;
         i_last <= '0;
         j_last <= '0;
         f_last <= '0;
         n_last <= '0;
         u_last <= '0;
      end else begin
         state  <= state_nx;
         i      <= i_nx;
         j      <= j_nx;
         f_cnt  <= f_cnt_nx;
         n_cnt  <= n_cnt_nx;
         u_cnt  <= u_cnt_nx;
         i_last <= i_last_nx;
         j_last <= j_last_nx;
         f_last <= f_last_nx;
         n_last <= n_last_nx;
         u_last <= u_last_nx;
      end
   end

   always_comb begin
      state_nx           = state;
      i_nx               = i;
      j_nx               = j;
      f_cnt_nx           = f_cnt;
      n_cnt_nx           = n_cnt;
      u_cnt_nx           = u_cnt;
      i_last_nx          = i_last;
      j_last_nx          = j_last;
      f_last_nx          = f_last;
      n_last_nx          = n_last;
      u_last_nx          = u_last;
      busy               = (state != IDLE);
      done               = 1'b0;
      cfg_error          = 1'b0;
      reset_accumulation = 1'b0;
      accumulate_ipsum   = 1'b0;
      ipsum_pop          = 1'b0;
      opsum_push         = 1'b0;
      reset_ifmap_spad   = 1'b0;
      reset_filter_spad  = 1'b0;
      shift              = 1'b0;
      rd_data            = 1'b0;
      wr_psum            = 1'b0;

      if (abort && (state != IDLE)) begin
         state_nx          = IDLE;
         i_nx              = '0;
         j_nx              = '0;
         f_cnt_nx          = '0;
         n_cnt_nx          = '0;
         u_cnt_nx          = '0;
         reset_ifmap_spad  = 1'b1;
         reset_filter_spad = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               // Terminal counts are stored so the loops compare against *_last directly.
               if (start && !abort) begin
                  if (cfg_ok) begin
                     state_nx  = PROCESS;
                     i_last_nx = IFMAP_ADDR_WIDTH'(sq_in - 32'd1);
                     j_last_nx = PSUM_ADDR_WIDTH'(cfg_in.p - CFG_FIELD_W'(1));
                     f_last_nx = F - F_WIDTH'(1);
                     n_last_nx = n - N_WIDTH'(1);
                     u_last_nx = UQ_WIDTH'(U) * UQ_WIDTH'(q) - UQ_WIDTH'(1);
                  end else begin
                     cfg_error = 1'b1;
                  end
               end
            end
            PROCESS: begin
               if (!await) begin
                  if (skip_en && ifmap_zero && (i != '0) && (j == '0)) begin
                     if (i == i_last) begin
                        i_nx     = '0;
                        state_nx = ACCUMULATE;
                     end else begin
                        i_nx = i + IFMAP_ADDR_WIDTH'(1);
                     end
                  end else begin
                     rd_data            = 1'b1;
                     wr_psum            = 1'b1;
                     reset_accumulation = (i == '0);
                     if (j == j_last) begin
                        j_nx = '0;
                        if (i == i_last) begin
                           i_nx     = '0;
                           state_nx = ACCUMULATE;
                        end else begin
                           i_nx = i + IFMAP_ADDR_WIDTH'(1);
                        end
                     end else begin
                        j_nx = j + PSUM_ADDR_WIDTH'(1);
                     end
                  end
               end
            end
            ACCUMULATE: begin
               if (!ipsum_fifo_empty && !opsum_fifo_full) begin
                  accumulate_ipsum = 1'b1;
                  ipsum_pop        = 1'b1;
                  opsum_push       = 1'b1;
                  if (j == j_last) begin
                     j_nx = '0;
                     if (f_cnt == f_last) begin
                        f_cnt_nx = '0;
                        state_nx = LOAD;
                     end else begin
                        f_cnt_nx = f_cnt + F_WIDTH'(1);
                        state_nx = STRIDE;
                     end
                  end else begin
                     j_nx = j + PSUM_ADDR_WIDTH'(1);
                  end
               end
            end
            STRIDE: begin
               shift = 1'b1;
               if (u_cnt == u_last) begin
                  u_cnt_nx = '0;
                  state_nx = PROCESS;
               end else begin
                  u_cnt_nx = u_cnt + UQ_WIDTH'(1);
               end
            end
            LOAD: begin
               reset_ifmap_spad = 1'b1;
               if (n_cnt == n_last) begin
                  reset_filter_spad = 1'b1;
                  n_cnt_nx          = '0;
                  state_nx          = FINISH;
               end else begin
                  n_cnt_nx = n_cnt + N_WIDTH'(1);
                  state_nx = PROCESS;
               end
            end
            FINISH: begin
               done     = 1'b1;
               state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer: outputs sampled on the rising edge, inputs driven after the falling edge.
module tb_pe_sequencer;

   logic       clk = 1'b0;
   logic       reset, start, abort, await, skip_en, ifmap_zero;
   logic [3:0] S;
   logic [5:0] F;
   logic [2:0] U, n, q;
   logic [4:0] p;
   logic       busy, done, cfg_error, reset_accumulation, accumulate_ipsum;
   logic       ipsum_pop, opsum_push, reset_ifmap_spad, reset_filter_spad;
   logic [3:0] ifmap_addr;
   logic [7:0] filter_addr;
   logic [4:0] psum_addr;
   logic       shift, rd_data, wr_psum, ipsum_fifo_empty, opsum_fifo_full;
   logic       zero_en;
   logic [3:0] zero_row;

   int n_chk = 0;
   int n_pass = 0;
   int rd_cnt, racc_cnt, acc_cnt, pop_cnt, push_cnt, shift_cnt, ifr_cnt, ffr_cnt;
   int done_cnt, done_cyc, last_busy, win_strobe, hold_pa, ab_ifr, ab_ffr, ab_fifo, ab_busy;
   int fa_q[$];

   pe_sequencer dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .abort              (abort),
      .await              (await),
      .skip_en            (skip_en),
      .ifmap_zero         (ifmap_zero),
      .S                  (S),
      .F                  (F),
      .U                  (U),
      .n                  (n),
      .p                  (p),
      .q                  (q),
      .busy               (busy),
      .done               (done),
      .cfg_error          (cfg_error),
      .reset_accumulation (reset_accumulation),
      .accumulate_ipsum   (accumulate_ipsum),
      .ipsum_pop          (ipsum_pop),
      .opsum_push         (opsum_push),
      .reset_ifmap_spad   (reset_ifmap_spad),
      .reset_filter_spad  (reset_filter_spad),
      .ifmap_addr         (ifmap_addr),
      .filter_addr        (filter_addr),
      .psum_addr          (psum_addr),
      .shift              (shift),
      .rd_data            (rd_data),
      .wr_psum            (wr_psum),
      .ipsum_fifo_empty   (ipsum_fifo_empty),
      .opsum_fifo_full    (opsum_fifo_full)
   );

   always #5 clk = ~clk;

   assign ifmap_zero = zero_en && (ifmap_addr == zero_row);

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic set_cfg(input int s_v, input int f_v, input int u_v,
                          input int n_v, input int p_v, input int q_v);
      S = 4'(s_v);
      F = 6'(f_v);
      U = 3'(u_v);
      n = 3'(n_v);
      p = 5'(p_v);
      q = 3'(q_v);
   endtask

   // Cycle 0 is the start cycle; config inputs are scrambled afterwards to prove they were latched.
   task automatic run(input int max_cyc, input int aw_from, input int aw_to,
                      input int em_from, input int em_to, input int ab_at);
      rd_cnt = 0; racc_cnt = 0; acc_cnt = 0; pop_cnt = 0; push_cnt = 0; shift_cnt = 0;
      ifr_cnt = 0; ffr_cnt = 0; done_cnt = 0; done_cyc = -1; last_busy = -1;
      win_strobe = 0; hold_pa = -1; ab_ifr = -1; ab_ffr = -1; ab_fifo = -1; ab_busy = -1;
      fa_q.delete();
      start = 1'b1;
      for (int c = 0; c < max_cyc; c++) begin
         await            = (c >= aw_from) && (c <= aw_to);
         ipsum_fifo_empty = (c >= em_from) && (c <= em_to);
         abort            = (c == ab_at);
         @(posedge clk);
         if (rd_data) begin
            rd_cnt++;
            fa_q.push_back(int'(filter_addr));
         end
         if (reset_accumulation) racc_cnt++;
         if (accumulate_ipsum) acc_cnt++;
         if (ipsum_pop) pop_cnt++;
         if (opsum_push) push_cnt++;
         if (shift) shift_cnt++;
         if (reset_ifmap_spad) ifr_cnt++;
         if (reset_filter_spad) ffr_cnt++;
         if ((await || ipsum_fifo_empty) &&
             (rd_data || wr_psum || ipsum_pop || opsum_push || accumulate_ipsum)) win_strobe++;
         if (c == em_from + 2) hold_pa = int'(psum_addr);
         if (c == ab_at) begin
            ab_ifr  = int'(reset_ifmap_spad);
            ab_ffr  = int'(reset_filter_spad);
            ab_fifo = int'(ipsum_pop | opsum_push);
         end
         if (c == ab_at + 1) ab_busy = int'(busy);
         if (done) begin
            done_cnt++;
            done_cyc = c;
         end
         last_busy = int'(busy);
         @(negedge clk);
         #1;
         start = 1'b0;
         S = 4'd7;
         p = 5'd2;
      end
      await = 1'b0;
      ipsum_fifo_empty = 1'b0;
      abort = 1'b0;
   endtask

   task automatic check_seq(input string tag, input int per_pass);
      int bad = 0;
      foreach (fa_q[k]) if (fa_q[k] != (k % per_pass)) bad++;
      check(tag, bad, 0);
   endtask

   task automatic cfg_try(input string tag, input logic ab, input int exp_err, input int exp_busy);
      start = 1'b1;
      abort = ab;
      @(posedge clk);
      check({tag, "_err"}, cfg_error, exp_err);
      check({tag, "_busy0"}, busy, 0);
      @(negedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      @(posedge clk);
      check({tag, "_busy1"}, busy, exp_busy);
      check({tag, "_err1"}, cfg_error, 0);
      @(negedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; await = 1'b0; skip_en = 1'b0;
      ipsum_fifo_empty = 1'b0; opsum_fifo_full = 1'b0; zero_en = 1'b0; zero_row = 4'd0;
      set_cfg(3, 2, 1, 1, 4, 1);
      repeat (2) @(negedge clk);
      #1;
      @(posedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd", rd_data, 0);
      check("rst_spad", {reset_ifmap_spad, reset_filter_spad, shift, ipsum_pop}, 0);
      check("rst_addr", {ifmap_addr, filter_addr, psum_addr}, 0);
      @(negedge clk);
      #1;
      reset = 1'b0;

      set_cfg(3, 2, 1, 1, 4, 1);
      run(38, -1, -1, -1, -1, -1);
      check("base_rd", rd_cnt, 24);
      check_seq("base_faseq", 12);
      check("base_racc", racc_cnt, 8);
      check("base_acc", acc_cnt, 8);
      check("base_pop", pop_cnt, 8);
      check("base_push", push_cnt, 8);
      check("base_shift", shift_cnt, 1);
      check("base_ifr", ifr_cnt, 1);
      check("base_ffr", ffr_cnt, 1);
      check("base_done_cnt", done_cnt, 1);
      check("base_done_cyc", done_cyc, 35);
      check("base_idle", last_busy, 0);

      set_cfg(3, 2, 1, 1, 4, 1);
      run(41, 5, 7, -1, -1, -1);
      check("await_rd", rd_cnt, 24);
      check_seq("await_faseq", 12);
      check("await_quiet", win_strobe, 0);
      check("await_done_cyc", done_cyc, 38);

      set_cfg(3, 2, 1, 1, 4, 1);
      run(43, -1, -1, 14, 18, -1);
      check("empty_quiet", win_strobe, 0);
      check("empty_jhold", hold_pa, 1);
      check("empty_pop", pop_cnt, 8);
      check("empty_push", push_cnt, 8);
      check("empty_done_cyc", done_cyc, 40);

      skip_en = 1'b1; zero_en = 1'b1; zero_row = 4'd1;
      set_cfg(3, 1, 1, 1, 4, 1);
      run(18, -1, -1, -1, -1, -1);
      check("skip_rd", rd_cnt, 8);
      check("skip_racc", racc_cnt, 4);
      check("skip_fa4", (fa_q.size() > 4) ? fa_q[4] : -1, 8);
      check("skip_done_cyc", done_cyc, 15);
      skip_en = 1'b0; zero_en = 1'b0;

      set_cfg(3, 2, 1, 1, 4, 1);
      run(10, -1, -1, -1, -1, -1);
      check("mid_busy", busy, 1);
      reset = 1'b1;
      #1;
      check("areset_busy", busy, 0);
      check("areset_addr", {ifmap_addr, psum_addr}, 0);
      check("areset_done", done, 0);
      @(negedge clk);
      #1;
      reset = 1'b0;

      set_cfg(3, 2, 1, 1, 4, 1);
      run(22, -1, -1, -1, -1, 17);
      check("abort_shift_seen", shift_cnt, 0);
      check("abort_ifr", ab_ifr, 1);
      check("abort_ffr", ab_ffr, 1);
      check("abort_fifo", ab_fifo, 0);
      check("abort_busy_next", ab_busy, 0);
      check("abort_no_done", done_cnt, 0);

      set_cfg(3, 2, 1, 1, 4, 1);
      run(38, -1, -1, -1, -1, -1);
      check("rerun_rd", rd_cnt, 24);
      check_seq("rerun_faseq", 12);
      check("rerun_done_cyc", done_cyc, 35);

      set_cfg(3, 2, 1, 1, 0, 1);
      cfg_try("cfg_p0", 1'b0, 1, 0);
      set_cfg(5, 2, 1, 1, 4, 4);
      cfg_try("cfg_sq20", 1'b0, 1, 0);
      set_cfg(4, 2, 1, 1, 17, 4);
      cfg_try("cfg_sqp272", 1'b0, 1, 0);
      set_cfg(3, 2, 1, 1, 0, 1);
      cfg_try("cfg_abort_start", 1'b1, 0, 0);
      set_cfg(4, 2, 1, 1, 16, 4);
      cfg_try("cfg_edge_ok", 1'b0, 0, 1);
      abort = 1'b1;
      @(negedge clk);
      #1;
      abort = 1'b0;
      @(posedge clk);
      check("edge_abort_idle", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pe_sequencer.md
Name: pe_sequencer

Overview:
Parametrised successor to the PE row-stationary controller. It sequences the ifmap, filter and psum scratchpads of one PE through these phases, repeated per filter row:
- MAC pass
- ipsum accumulation
- stride shift
- ifmap reload

New over the previous generation: run-time config latched on start with legality check, zero-skip of ifmap entries, explicit FIFO pop/push strobes, abort, and a done pulse.

Parameters:
F_WIDTH, 6, width of ofmap-row count F
S_WIDTH, 4, width of filter width S
U_WIDTH, 3, width of stride U
N_WIDTH, 3, width of ifmap batch count n
P_WIDTH, 5, width of filter count p
Q_WIDTH, 3, width of channel count q
IFMAP_ADDR_WIDTH, 4, ifmap spad address width
FILTER_ADDR_WIDTH, 8, filter spad address width
PSUM_ADDR_WIDTH, 5, psum spad address width

Ports:
clk  in  1  clock; all state updates on the falling edge, so the datapath samples on the rising edge
reset  in  1  asynchronous, active-high
start  in  1  begin a run (sampled in IDLE only)
abort  in  1  terminate any run
await  in  1  stall the MAC pass
skip_en  in  1  enable zero-skip
ifmap_zero  in  1  ifmap spad entry at ifmap_addr is zero
S,F,U,n,p,q  in  *_WIDTH each  run configuration
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse on normal completion
cfg_error  out  1  one-cycle pulse when start is rejected
reset_accumulation  out  1  clear the MAC accumulator
accumulate_ipsum  out  1  add ipsum to psum[psum_addr]
ipsum_pop  out  1  pop the ipsum FIFO
opsum_push  out  1  push to the opsum FIFO
reset_ifmap_spad  out  1  clear the ifmap spad
reset_filter_spad  out  1  clear the filter spad
ifmap_addr  out  IFMAP_ADDR_WIDTH  current i
filter_addr  out  FILTER_ADDR_WIDTH  i*p+j
psum_addr  out  PSUM_ADDR_WIDTH  current j
shift  out  1  shift the ifmap spad by one entry
rd_data  out  1  read the spads
wr_psum  out  1  write psum
ipsum_fifo_empty  in  1
opsum_fifo_full  in  1

Behaviour:
- Reset: state IDLE; all counters 0; every output 0.
- Combinational outputs are decoded from registered state and counters. Addresses are combinational from i and j.
- Config:
  - S,F,U,n,p,q are latched on start in IDLE. Inputs are ignored thereafter.
  - start is rejected if any field is 0, or S*q > 2^IFMAP_ADDR_WIDTH, or p > 2^PSUM_ADDR_WIDTH, or S*q*p > 2^FILTER_ADDR_WIDTH.
  - On rejection: cfg_error pulses one cycle, state stays IDLE, busy stays 0.
- States: IDLE, PROCESS, ACCUMULATE, STRIDE, LOAD, FINISH.
- IDLE: busy=0. A legal start moves to PROCESS.
- PROCESS, per cycle with await=0:
  - rd_data=1, wr_psum=1.
  - reset_accumulation=1 iff i==0.
  - j increments. At j==p-1: j=0 and i increments.
  - At i==S*q-1 and j==p-1: i=0, go to ACCUMULATE.
- PROCESS with await=1: hold; no strobes.
- Zero-skip: when skip_en=1, ifmap_zero=1, i>0 and j==0:
  - No strobes that cycle.
  - i advances (or, if i is last, go to ACCUMULATE).
  - j stays 0.
  - The row at i==0 is never skipped, so the accumulator is always cleared.
- ACCUMULATE:
  - When ipsum_fifo_empty=0 and opsum_fifo_full=0: accumulate_ipsum=1, ipsum_pop=1, opsum_push=1, j increments.
  - At j==p-1: j=0 and the F counter advances. If F counter==F-1: F counter=0, go to LOAD. Otherwise go to STRIDE.
  - Otherwise hold; no strobes.
- STRIDE: shift=1 for exactly U*q cycles (U counter width U_WIDTH+Q_WIDTH), then PROCESS.
- LOAD: reset_ifmap_spad=1 for one cycle.
  - If n counter==n-1: reset_filter_spad=1, n counter=0, go to FINISH.
  - Otherwise n counter increments, go to PROCESS.
- FINISH: done=1 for one cycle, then IDLE.
- abort: highest priority, any non-IDLE state.
  - Next state IDLE; all counters 0.
  - reset_ifmap_spad and reset_filter_spad are asserted during the abort cycle.
  - No done, no FIFO strobes.
  - abort in IDLE has no effect; abort together with start in IDLE gives abort priority, so the start is ignored.
- Asynchronous reset mid-run: immediate return to IDLE; no done.

Decomposition:
- Package pe_pkg holds state_t (3-bit enum) and the cfg_t struct {S,F,U,n,p,q}.
- One sub-module, pe_cfg_check: combinational legality check of cfg_t against the address parameters, output cfg_ok.

Test Plan:
- S=3,q=1,p=4,F=2,U=1,n=1, FIFOs ready, no await:
  - 12 PROCESS cycles with filter_addr 0..11.
  - 4 accumulate cycles.
  - 1 shift cycle.
  - 12 PROCESS, 4 accumulate, 1 LOAD.
  - done pulses at cycle 35 after start.
- Same config with await high for 3 cycles mid-PROCESS -> the address sequence is unchanged and done is delayed by exactly 3 cycles.
- skip_en=1, ifmap_zero=1 when i==1 (S=3,q=1,p=4) -> row 1 takes 1 cycle with no rd_data/wr_psum; PROCESS lasts 9 cycles; row 0 is never skipped.
- ipsum_fifo_empty=1 for 5 cycles during ACCUMULATE -> no pops or pushes during those cycles; j holds; the pop count still totals p per F.
- start with p=0, then with S=5,q=4 (S*q=20 > 16) -> cfg_error pulses; busy stays 0.
- abort during STRIDE -> next cycle busy=0, both spad resets seen, no done; a following start runs the full sequence from i=j=0.
